ps2_rx_scan: RTL and testbench



---
 rtl/ps2_pkg.sv | 20 ++
 rtl/ps2_evt_fifo.sv | 53 +++++
 rtl/ps2_rx_scan.sv | 198 +++++++++++++++++++
 tb/tb_ps2_rx_scan.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants and the event record for the PS/2 scan-code receiver.
package ps2_pkg;

    localparam logic [7:0] BRK = 8'hF0;
    localparam logic [7:0] EXT = 8'hE0;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_FRAME   = 2'd1;
    localparam logic [1:0] ERR_PARITY  = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam int EVT_W = 10;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_evt_t;

endpackage

// File: rtl/ps2_evt_fifo.sv
// First-word-fall-through FIFO for decoded key events; a push while full is
// only accepted when a pop frees a slot in the same cycle.
module ps2_evt_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Head reads as zero while empty so the exported code is clean at reset.
    assign dout = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_rx_scan.sv
// PS/2 keyboard receiver: pin conditioning, frame capture and checking,
// E0/F0 prefix decoding and a buffered make/break event stream.
module ps2_rx_scan
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int FIFO_DEPTH     = 4,
    parameter int REPORT_MAKE    = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2c,
    input  logic       ps2d,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_brk,
    output logic       err_tick,
    output logic [1:0] err_code,
    output logic       ovf,
    output logic       rx_busy
);
    localparam int              WD_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;

    logic                  c_s1, c_s2, d_s1, d_s2;
    logic [FILTER_LEN-1:0] filt_sr;
    logic                  filt_clk;
    logic                  fall_edge;

    logic [1:0]      state;
    logic [10:0]     shreg;
    logic [3:0]      bit_cnt;
    logic [WD_W-1:0] wd_cnt;

    logic       timeout_hit;
    logic       frame_bad;
    logic       parity_bad;
    logic       frame_ok;
    logic       err_now;
    logic [1:0] err_kind;
    logic [7:0] rx_byte;

    logic     ext_p, brk_p;
    logic     push_r;
    ps2_evt_t push_evt;
    ps2_evt_t head;
    logic     fifo_full, fifo_empty;

    // Everything resets to the idle-bus level so no edge is seen on release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c_s1      <= 1'b1;
            c_s2      <= 1'b1;
            d_s1      <= 1'b1;
            d_s2      <= 1'b1;
            filt_sr   <= '1;
            filt_clk  <= 1'b1;
            fall_edge <= 1'b0;
        end else begin
            c_s1      <= ps2c;
            c_s2      <= c_s1;
            d_s1      <= ps2d;
            d_s2      <= d_s1;
            filt_sr   <= {filt_sr[FILTER_LEN-2:0], c_s2};
            fall_edge <= 1'b0;
            if (&filt_sr) begin
                filt_clk <= 1'b1;
            end else if (~|filt_sr) begin
                filt_clk  <= 1'b0;
                fall_edge <= filt_clk;
            end
        end
    end

    assign timeout_hit = (state == S_SHIFT) && !fall_edge && (wd_cnt == WD_LIMIT);
    assign frame_bad   = shreg[0] | ~shreg[10];
    assign parity_bad  = ~(^shreg[9:1]);
    assign rx_byte     = shreg[8:1];
    assign frame_ok    = (state == S_CHECK) && !frame_bad && !parity_bad;
    assign rx_busy     = (state != S_IDLE);

    // Bits arrive LSB first, so shifting in at the top leaves start in bit 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            wd_cnt  <= '0;
        end else begin
            if (fall_edge)               wd_cnt <= '0;
            else if (wd_cnt != WD_LIMIT) wd_cnt <= wd_cnt + 1'b1;

            case (state)
                S_IDLE: begin
                    if (fall_edge) begin
                        shreg   <= {d_s2, shreg[10:1]};
                        bit_cnt <= 4'd10;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (fall_edge) begin
                        shreg   <= {d_s2, shreg[10:1]};
                        bit_cnt <= bit_cnt - 1'b1;
                        if (bit_cnt == 4'd1) state <= S_CHECK;
                    end else if (timeout_hit) begin
                        shreg <= '0;
                        state <= S_IDLE;
                    end
                end
                S_CHECK: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        err_now  = 1'b0;
        err_kind = ERR_NONE;
        if (timeout_hit) begin
            err_now  = 1'b1;
            err_kind = ERR_TIMEOUT;
        end else if (state == S_CHECK) begin
            if (frame_bad) begin
                err_now  = 1'b1;
                err_kind = ERR_FRAME;
            end else if (parity_bad) begin
                err_now  = 1'b1;
                err_kind = ERR_PARITY;
            end
        end
    end

    // Prefix bytes only arm flags; a plain byte consumes them and may emit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_tick <= 1'b0;
            err_code <= ERR_NONE;
            ext_p    <= 1'b0;
            brk_p    <= 1'b0;
            push_r   <= 1'b0;
            push_evt <= '0;
        end else begin
            err_tick <= err_now;
            push_r   <= 1'b0;
            if (err_now) begin
                err_code <= err_kind;
                ext_p    <= 1'b0;
                brk_p    <= 1'b0;
            end else if (frame_ok) begin
                if (rx_byte == EXT) begin
                    ext_p <= 1'b1;
                end else if (rx_byte == BRK) begin
                    brk_p <= 1'b1;
                end else begin
                    push_r        <= (REPORT_MAKE != 0) || brk_p;
                    push_evt.ext  <= ext_p;
                    push_evt.brk  <= brk_p;
                    push_evt.code <= rx_byte;
                    ext_p         <= 1'b0;
                    brk_p         <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                               ovf <= 1'b0;
        else if (push_r && fifo_full && !ev_ready)  ovf <= 1'b1;
    end

    ps2_evt_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_r),
        .din     (push_evt),
        .pop     (ev_ready),
        .dout    (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign ev_valid = ~fifo_empty;
    assign ev_code  = head.code;
    assign ev_ext   = head.ext;
    assign ev_brk   = head.brk;

endmodule

// File: tb/tb_ps2_rx_scan.sv
// Bench for ps2_rx_scan: two instances (break-only and make+break) driven by the
// same PS/2 frames, checked against a queue-based model of the decoded events.
module tb_ps2_rx_scan;

    localparam int FL    = 4;
    localparam int TO    = 200;
    localparam int DEPTH = 4;
    localparam int H     = 20;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic ps2c = 1'b1;
    logic ps2d = 1'b1;
    logic ready0 = 1'b1;
    logic ready1 = 1'b1;

    logic       ev_valid0, ev_ext0, ev_brk0, err_tick0, ovf0, rx_busy0;
    logic [7:0] ev_code0;
    logic [1:0] err_code0;
    logic       ev_valid1, ev_ext1, ev_brk1, err_tick1, ovf1, rx_busy1;
    logic [7:0] ev_code1;
    logic [1:0] err_code1;

    always #5 clk = ~clk;

    ps2_rx_scan #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(DEPTH), .REPORT_MAKE(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .ps2c(ps2c), .ps2d(ps2d),
        .ev_valid(ev_valid0), .ev_ready(ready0), .ev_code(ev_code0), .ev_ext(ev_ext0), .ev_brk(ev_brk0),
        .err_tick(err_tick0), .err_code(err_code0), .ovf(ovf0), .rx_busy(rx_busy0));

    ps2_rx_scan #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(DEPTH), .REPORT_MAKE(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .ps2c(ps2c), .ps2d(ps2d),
        .ev_valid(ev_valid1), .ev_ready(ready1), .ev_code(ev_code1), .ev_ext(ev_ext1), .ev_brk(ev_brk1),
        .err_tick(err_tick1), .err_code(err_code1), .ovf(ovf1), .rx_busy(rx_busy1));

    int checks = 0;
    int failures = 0;

    logic [9:0] exp_q0[$];
    logic [9:0] exp_q1[$];
    logic [1:0] err_q0[$];
    logic [1:0] err_q1[$];
    logic [1:0] last_err0, last_err1;
    logic [9:0] last_pop0, last_pop1;
    int         pops0 = 0;
    int         pops1 = 0;
    bit         ext_m, brk_m, ovf_m0, ovf_m1;
    bit         rand_ready = 1'b0;
    bit         lat_chk = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        exp_q0.delete();
        exp_q1.delete();
        err_q0.delete();
        err_q1.delete();
        ext_m = 1'b0;
        brk_m = 1'b0;
        ovf_m0 = 1'b0;
        ovf_m1 = 1'b0;
        last_err0 = 2'd0;
        last_err1 = 2'd0;
    endtask

    // Frame-level model: prefixes arm flags, any other byte yields an event.
    task automatic modelGood(input logic [7:0] b);
        logic [9:0] ev;
        if (b == 8'hE0) ext_m = 1'b1;
        else if (b == 8'hF0) brk_m = 1'b1;
        else begin
            ev = {ext_m, brk_m, b};
            if (brk_m) begin
                if (exp_q0.size() >= DEPTH) ovf_m0 = 1'b1;
                else exp_q0.push_back(ev);
            end
            if (exp_q1.size() >= DEPTH) ovf_m1 = 1'b1;
            else exp_q1.push_back(ev);
            ext_m = 1'b0;
            brk_m = 1'b0;
        end
    endtask

    task automatic modelErr(input logic [1:0] code);
        ext_m = 1'b0;
        brk_m = 1'b0;
        err_q0.push_back(code);
        err_q1.push_back(code);
    endtask

    task automatic latencyCheck();
        int n = 0;
        while (!dut0.fall_edge && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!dut0.fall_edge) begin
            checks++;
            failures++;
            $display("[TB] FAIL lat_edge actual=none required=stop_edge");
        end else begin
            @(negedge clk); checkOutput("lat_n1", 32'(ev_valid0), 0);
            @(negedge clk); checkOutput("lat_n2", 32'(ev_valid0), 0);
            @(negedge clk); checkOutput("lat_n3", 32'(ev_valid0), 1);
        end
    endtask

    // kind: 0 good, 1 parity, 2 start, 3 stop, 4 timeout after nbits, 5 abandon after nbits
    task automatic applyStimulus(input logic [7:0] d, input int kind, input int nbits);
        logic [10:0] bits;
        bits = {1'b1, ~(^d), d, 1'b0};
        if (kind == 1) bits[9] = ~bits[9];
        if (kind == 2) bits[0] = 1'b1;
        if (kind == 3) bits[10] = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            ps2d = bits[i];
            repeat (H) @(negedge clk);
            if (i == 10) begin
                if (kind == 0) modelGood(d);
                else modelErr((kind == 1) ? 2'd2 : 2'd1);
            end
            ps2c = 1'b0;
            fork
                repeat (H) @(negedge clk);
                if (lat_chk && i == 10) latencyCheck();
            join
            ps2c = 1'b1;
        end
        ps2d = 1'b1;
        if (kind == 4) begin
            modelErr(2'd3);
            checkOutput("busy_mid0", 32'(rx_busy0), 1);
            repeat (2 * TO) @(negedge clk);
        end
        repeat (H) @(negedge clk);
    endtask

    task automatic sendGood(input logic [7:0] d);
        applyStimulus(d, 0, 11);
    endtask

    task automatic setReady(input logic r0, input logic r1);
        @(posedge clk);
        #1;
        ready0 = r0;
        ready1 = r1;
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0 || err_q0.size() != 0 || err_q1.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        checkOutput("drain_q0", 32'(exp_q0.size()), 0);
        checkOutput("drain_q1", 32'(exp_q1.size()), 0);
        checkOutput("drain_err0", 32'(err_q0.size()), 0);
        checkOutput("drain_err1", 32'(err_q1.size()), 0);
        checkOutput("idle_valid0", 32'(ev_valid0), 0);
        checkOutput("idle_valid1", 32'(ev_valid1), 0);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_valid0"}, 32'(ev_valid0), 0);
        checkOutput({tag, "_code0"}, 32'({ev_ext0, ev_brk0, ev_code0}), 0);
        checkOutput({tag, "_tick0"}, 32'(err_tick0), 0);
        checkOutput({tag, "_errc0"}, 32'(err_code0), 0);
        checkOutput({tag, "_ovf0"}, 32'(ovf0), 0);
        checkOutput({tag, "_busy0"}, 32'(rx_busy0), 0);
        checkOutput({tag, "_valid1"}, 32'(ev_valid1), 0);
        checkOutput({tag, "_code1"}, 32'({ev_ext1, ev_brk1, ev_code1}), 0);
        checkOutput({tag, "_errc1"}, 32'(err_code1), 0);
        checkOutput({tag, "_ovf1"}, 32'({err_tick1, ovf1, rx_busy1}), 0);
    endtask

    // Compare process: every accepted pop and every error pulse against the model.
    always @(negedge clk) begin
        if (reset_n) begin
            if (ev_valid0 && ready0) begin
                if (exp_q0.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL ev0_extra actual=%0h required=none", {ev_ext0, ev_brk0, ev_code0});
                end else begin
                    checkOutput("ev0", 32'({ev_ext0, ev_brk0, ev_code0}), 32'(exp_q0.pop_front()));
                    pops0++;
                    last_pop0 = {ev_ext0, ev_brk0, ev_code0};
                end
            end
            if (ev_valid1 && ready1) begin
                if (exp_q1.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL ev1_extra actual=%0h required=none", {ev_ext1, ev_brk1, ev_code1});
                end else begin
                    checkOutput("ev1", 32'({ev_ext1, ev_brk1, ev_code1}), 32'(exp_q1.pop_front()));
                    pops1++;
                    last_pop1 = {ev_ext1, ev_brk1, ev_code1};
                end
            end
            if (err_tick0) begin
                if (err_q0.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL err0_extra actual=%0d required=none", err_code0);
                end else begin
                    last_err0 = err_q0.pop_front();
                    checkOutput("err_code0", 32'(err_code0), 32'(last_err0));
                end
            end else begin
                checkOutput("err_hold0", 32'(err_code0), 32'(last_err0));
            end
            if (err_tick1) begin
                if (err_q1.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL err1_extra actual=%0d required=none", err_code1);
                end else begin
                    last_err1 = err_q1.pop_front();
                    checkOutput("err_code1", 32'(err_code1), 32'(last_err1));
                end
            end else begin
                checkOutput("err_hold1", 32'(err_code1), 32'(last_err1));
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) begin
                ready0 = 1'($urandom_range(0, 1));
                ready1 = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        int p0, p1;
        logic [7:0] d;
        int r;

        modelReset();
        #2 reset_n = 1'b0;
        #1 checkReset("rst");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // Break-only filtering plus the three-cycle event latency
        p0 = pops0; p1 = pops1;
        sendGood(8'h1C);
        sendGood(8'hF0);
        lat_chk = 1'b1;
        sendGood(8'h1C);
        lat_chk = 1'b0;
        waitDrain();
        checkOutput("t1_pops0", 32'(pops0 - p0), 1);
        checkOutput("t1_evt0", 32'(last_pop0), 32'h11C);
        checkOutput("t1_pops1", 32'(pops1 - p1), 2);

        // Extended make and break
        p0 = pops0; p1 = pops1;
        sendGood(8'hE0); sendGood(8'h75);
        sendGood(8'hE0); sendGood(8'hF0); sendGood(8'h75);
        waitDrain();
        checkOutput("t2_pops1", 32'(pops1 - p1), 2);
        checkOutput("t2_evt1", 32'(last_pop1), 32'h375);
        checkOutput("t2_pops0", 32'(pops0 - p0), 1);

        // Parity error then a normal break
        p0 = pops0;
        applyStimulus(8'h1C, 1, 11);
        sendGood(8'hF0); sendGood(8'h1C);
        waitDrain();
        checkOutput("t3_err0", 32'(last_err0), 2);
        checkOutput("t3_pops0", 32'(pops0 - p0), 1);
        checkOutput("t3_evt0", 32'(last_pop0), 32'h11C);

        // Inter-bit timeout after five bits
        applyStimulus(8'h55, 4, 5);
        checkOutput("t4_busy0", 32'(rx_busy0), 0);
        checkOutput("t4_busy1", 32'(rx_busy1), 0);
        checkOutput("t4_err0", 32'(last_err0), 3);
        sendGood(8'hF0); sendGood(8'h29);
        waitDrain();
        checkOutput("t4_evt0", 32'(last_pop0), 32'h129);

        // Overflow with the consumer stalled
        p0 = pops0; p1 = pops1;
        setReady(1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            sendGood(8'hF0);
            sendGood(8'(k));
        end
        repeat (20) @(negedge clk);
        checkOutput("t5_ovf0", 32'(ovf0), 32'(ovf_m0));
        checkOutput("t5_ovf0_lit", 32'(ovf0), 1);
        checkOutput("t5_ovf1", 32'(ovf1), 1);
        checkOutput("t5_head0", 32'(ev_code0), 32'h01);
        setReady(1'b1, 1'b1);
        waitDrain();
        checkOutput("t5_pops0", 32'(pops0 - p0), 4);
        checkOutput("t5_pops1", 32'(pops1 - p1), 4);
        checkOutput("t5_last0", 32'(last_pop0), 32'h104);

        // Reset in the middle of a frame with an event still pending
        setReady(1'b0, 1'b0);
        sendGood(8'hF0); sendGood(8'h33);
        applyStimulus(8'hA5, 5, 6);
        checkOutput("t6_pre_valid0", 32'(ev_valid0), 1);
        checkOutput("t6_pre_busy0", 32'(rx_busy0), 1);
        @(negedge clk);
        #3 reset_n = 1'b0;
        #1 checkReset("t6");
        modelReset();
        ps2c = 1'b1;
        ps2d = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        setReady(1'b1, 1'b1);
        p0 = pops0;
        sendGood(8'hF0); sendGood(8'h5A);
        waitDrain();
        checkOutput("t6_pops0", 32'(pops0 - p0), 1);
        checkOutput("t6_evt0", 32'(last_pop0), 32'h15A);
        checkOutput("t6_err0", 32'(last_err0), 0);

        // Randomised traffic with a randomly stalling consumer
        rand_ready = 1'b1;
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 99) < 30) sendGood(8'hE0);
            if ($urandom_range(0, 99) < 50) sendGood(8'hF0);
            d = 8'($urandom_range(0, 255));
            while (d == 8'hE0 || d == 8'hF0) d = 8'($urandom_range(0, 255));
            r = $urandom_range(0, 99);
            if (r < 80) applyStimulus(d, 0, 11);
            else if (r < 95) applyStimulus(d, int'($urandom_range(1, 3)), 11);
            else applyStimulus(d, 4, int'($urandom_range(1, 10)));
        end
        rand_ready = 1'b0;
        setReady(1'b1, 1'b1);
        waitDrain();
        checkOutput("end_ovf0", 32'(ovf0), 32'(ovf_m0));
        checkOutput("end_ovf1", 32'(ovf1), 32'(ovf_m1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
